// File: rtl/psr_bank.sv
// -----------------------------------------------------------------------------
// psr_bank
//   Processor status register with a banked LIFO save stack for nested
//   exceptions. Holds the live condition flags, applies per-bit masked
//   updates from the ALU or shifter, saves the live flags on exception entry
//   and restores them on exception return.
//
//   For FLAG_W=4 the flag bit order is [3]=Z, [2]=N, [1]=C, [0]=V.
//
// Ports
//   clk              clock
//   resetn           asynchronous active-low reset
//   alu_flag_in      flags produced by the current ALU op
//   alu_upd_mask     1 = bit takes alu_flag_in, 0 = bit keeps its value
//   shifter_flag_in  flags produced by the shifter
//   shift            current op is a shift (selects the shifter path)
//   wen              commit a flag update this cycle
//   exc_entry        exception taken: save live flags
//   exc_return       exception return: restore saved flags
//   err_clr          clear sticky error bits
//   flag_out         live flags (registered)
//   depth_out        number of valid saved entries
//   stack_empty      depth_out == 0
//   stack_full       depth_out == DEPTH
//   ovf_err          sticky: entry attempted while full
//   udf_err          sticky: return attempted while empty
// -----------------------------------------------------------------------------
module psr_bank #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [FLAG_W-1:0] alu_flag_in,
    input  logic [FLAG_W-1:0] alu_upd_mask,
    input  logic [FLAG_W-1:0] shifter_flag_in,
    input  logic              shift,
    input  logic              wen,
    input  logic              exc_entry,
    input  logic              exc_return,
    input  logic              err_clr,
    output logic [FLAG_W-1:0] flag_out,
    output logic [CNT_W-1:0]  depth_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(1'b0);

    // Architectural state
    logic [FLAG_W-1:0] flag_r;
    logic [FLAG_W-1:0] stack_r [DEPTH];
    logic [CNT_W-1:0]  depth_r;
    logic              empty_r;
    logic              full_r;
    logic              ovf_r;
    logic              udf_r;

    // Combinational next-state
    logic [FLAG_W-1:0] shift_val_s;
    logic [FLAG_W-1:0] alu_val_s;
    logic [FLAG_W-1:0] upd_val_s;
    logic [FLAG_W-1:0] pop_val_s;
    logic [FLAG_W-1:0] flag_nxt_s;
    logic [CNT_W-1:0]  depth_nxt_s;
    logic              push_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic              ovf_nxt_s;
    logic              udf_nxt_s;

    // Candidate flag update: shifter path keeps bit 0, ALU path merges by mask
    always_comb begin
        shift_val_s    = shifter_flag_in;
        shift_val_s[0] = flag_r[0];
        alu_val_s      = (alu_flag_in & alu_upd_mask) | (flag_r & ~alu_upd_mask);
        if (shift) begin
            upd_val_s = shift_val_s;
        end else begin
            upd_val_s = alu_val_s;
        end
    end

    // Top-of-stack read (entry depth-1); one-hot OR mux over the entries
    always_comb begin
        pop_val_s = {FLAG_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pop_val_s = pop_val_s
                      | ({FLAG_W{depth_r == CNT_W'(i + 1)}} & stack_r[i]);
        end
    end

    // Priority resolution of exception entry/return versus flag write
    always_comb begin
        flag_nxt_s  = flag_r;
        depth_nxt_s = depth_r;
        push_s      = 1'b0;
        ovf_set_s   = 1'b0;
        udf_set_s   = 1'b0;
        case ({exc_entry, exc_return})
            2'b11: begin
                // Simultaneous entry and return cancel out: nothing moves
                flag_nxt_s = flag_r;
            end
            2'b01: begin
                if (!empty_r) begin
                    flag_nxt_s  = pop_val_s;
                    depth_nxt_s = depth_r - ONE_C;
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            2'b10: begin
                // Handler inherits the live flags, so flag_r is left alone
                if (!full_r) begin
                    push_s      = 1'b1;
                    depth_nxt_s = depth_r + ONE_C;
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            2'b00: begin
                if (wen) begin
                    flag_nxt_s = upd_val_s;
                end else begin
                    flag_nxt_s = flag_r;
                end
            end
            default: begin
                flag_nxt_s = flag_r;
            end
        endcase
    end

    // Sticky error next-state: a new error outranks a same-cycle clear
    always_comb begin
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (err_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (udf_set_s) begin
            udf_nxt_s = 1'b1;
        end else if (err_clr) begin
            udf_nxt_s = 1'b0;
        end else begin
            udf_nxt_s = udf_r;
        end
    end

    // Live flags, depth, decoded status and sticky errors
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flag_r  <= {FLAG_W{1'b0}};
            depth_r <= ZERO_C;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            flag_r  <= flag_nxt_s;
            depth_r <= depth_nxt_s;
            // Status decoded from next depth so it lines up with depth_r
            empty_r <= (depth_nxt_s == ZERO_C);
            full_r  <= (depth_nxt_s == DEPTH_C);
            ovf_r   <= ovf_nxt_s;
            udf_r   <= udf_nxt_s;
        end
    end

    // Save stack: push writes the pre-update live flags at index depth
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {FLAG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (depth_r == CNT_W'(i))) begin
                    stack_r[i] <= flag_r;
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
        end
    end

    assign flag_out    = flag_r;
    assign depth_out   = depth_r;
    assign stack_empty = empty_r;
    assign stack_full  = full_r;
    assign ovf_err     = ovf_r;
    assign udf_err     = udf_r;

endmodule

// File: tb/tb_psr_bank.sv
// -----------------------------------------------------------------------------
// tb_psr_bank
//   Self-checking bench for psr_bank (FLAG_W=4, DEPTH=4). A behavioural model
//   (plain integers plus a queue used as the save stack) predicts every
//   output after each clock; directed steps cover the documented scenarios
//   and a randomized phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_psr_bank;

    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              resetn;
    logic [FLAG_W-1:0] alu_flag_in;
    logic [FLAG_W-1:0] alu_upd_mask;
    logic [FLAG_W-1:0] shifter_flag_in;
    logic              shift;
    logic              wen;
    logic              exc_entry;
    logic              exc_return;
    logic              err_clr;
    logic [FLAG_W-1:0] flag_out;
    logic [CNT_W-1:0]  depth_out;
    logic              stack_empty;
    logic              stack_full;
    logic              ovf_err;
    logic              udf_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [FLAG_W-1:0] m_flags;
    logic [FLAG_W-1:0] m_stack [$];
    logic              m_ovf;
    logic              m_udf;

    psr_bank #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .alu_flag_in    (alu_flag_in),
        .alu_upd_mask   (alu_upd_mask),
        .shifter_flag_in(shifter_flag_in),
        .shift          (shift),
        .wen            (wen),
        .exc_entry      (exc_entry),
        .exc_return     (exc_return),
        .err_clr        (err_clr),
        .flag_out       (flag_out),
        .depth_out      (depth_out),
        .stack_empty    (stack_empty),
        .stack_full     (stack_full),
        .ovf_err        (ovf_err),
        .udf_err        (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model
    task automatic chk_all(input string tag);
        chk({tag, ".flag"},  32'(flag_out),    32'(m_flags));
        chk({tag, ".depth"}, 32'(depth_out),   32'(m_stack.size()));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        chk({tag, ".udf"},   32'(udf_err),     32'(m_udf));
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_stack.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock of the model, computed from the documented rules
    task automatic model_step();
        logic [FLAG_W-1:0] nv;
        logic ovf_set = 1'b0;
        logic udf_set = 1'b0;
        if (shift) nv = {shifter_flag_in[3:1], m_flags[0]};
        else       nv = (alu_flag_in & alu_upd_mask) | (m_flags & ~alu_upd_mask);
        if (exc_entry && exc_return) begin
            // no-op
        end else if (exc_return) begin
            if (m_stack.size() > 0) m_flags = m_stack.pop_back();
            else udf_set = 1'b1;
        end else if (exc_entry) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else ovf_set = 1'b1;
        end else if (wen) begin
            m_flags = nv;
        end
        m_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_udf = udf_set ? 1'b1 : (err_clr ? 1'b0 : m_udf);
    endtask

    task automatic drive(input logic [3:0] alu, input logic [3:0] mask,
                         input logic [3:0] shf, input logic sh, input logic we,
                         input logic en, input logic ret, input logic clr);
        alu_flag_in     = alu;
        alu_upd_mask    = mask;
        shifter_flag_in = shf;
        shift           = sh;
        wen             = we;
        exc_entry       = en;
        exc_return      = ret;
        err_clr         = clr;
    endtask

    // Apply inputs, clock once, advance model, check #1 after the edge
    task automatic cyc(input string tag, input logic [3:0] alu, input logic [3:0] mask,
                       input logic [3:0] shf, input logic sh, input logic we,
                       input logic en, input logic ret, input logic clr);
        drive(alu, mask, shf, sh, we, en, ret, clr);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic set_flags(input string tag, input logic [3:0] v);
        cyc(tag, v, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk_all("reset");
        resetn = 1'b1;

        // Masked ALU updates
        set_flags("add", 4'b1010);
        chk("add.const", 32'(flag_out), 32'h0000000a);
        cyc("logic", 4'b0101, 4'b1100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("logic.const", 32'(flag_out), 32'h00000006);
        cyc("mov", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mov.const", 32'(flag_out), 32'h00000006);

        // Shifter path keeps bit 0; wen=0 holds
        set_flags("pre_shift", 4'b0111);
        cyc("shift", 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("shift.const", 32'(flag_out), 32'h00000009);
        set_flags("pre_shift2", 4'b0111);
        cyc("shift_hold", 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("shift_hold.const", 32'(flag_out), 32'h00000007);

        // Nested save/restore; entry ignores a concurrent wen
        cyc("ent1", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ent1.flag_kept", 32'(flag_out), 32'h00000007);
        set_flags("set1", 4'b0001);
        cyc("ent2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_flags("set2", 4'b0010);
        cyc("ent3", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_flags("set3", 4'b0100);
        chk("nest.depth3", 32'(depth_out), 32'd3);
        cyc("ret1", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ret1.const", 32'(flag_out), 32'h00000002);
        cyc("ret2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ret2.const", 32'(flag_out), 32'h00000001);
        cyc("ret3", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ret3.const", 32'(flag_out), 32'h00000007);
        chk("ret3.empty", 32'(stack_empty), 32'd1);

        // Overflow on fifth entry, clear, simultaneous entry+return, set-wins
        for (int i = 0; i < 5; i++) begin
            cyc("fill", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("full.depth", 32'(depth_out), 32'd4);
        chk("full.flag", 32'(stack_full), 32'd1);
        chk("full.ovf", 32'(ovf_err), 32'd1);
        chk("full.flags_kept", 32'(flag_out), 32'h00000007);
        cyc("clr", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr.ovf", 32'(ovf_err), 32'd0);
        cyc("both", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("both.flag", 32'(flag_out), 32'h00000007);
        chk("both.depth", 32'(depth_out), 32'd4);
        cyc("ovf_clr", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovf_clr.ovf", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc("drain", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc("udf", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("udf.err", 32'(udf_err), 32'd1);
        chk("udf.flags_kept", 32'(flag_out), 32'h00000007);
        cyc("clr2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 4'($urandom), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 1));
        end

        // Reset asserted between edges takes effect immediately
        cyc("rst_pre0", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_flags("rst_pre1", 4'b1101);
        while (m_stack.size() > 0) begin
            cyc("rst_pre2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc("rst_push1", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rst_push2", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_push.depth", 32'(depth_out), 32'd2);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("midrst.flag", 32'(flag_out), 32'h00000000);
        chk("midrst.depth", 32'(depth_out), 32'd0);
        chk_all("midrst");
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst_ret", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_ret.udf", 32'(udf_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
